serial_full_adder: RTL and testbench

Bit-serial WIDTH-bit adder built around a single full-adder cell (the AND/XOR/OR gate network of the full adder) plus a carry flip-flop. It consumes one bit pair per clock, LSB first. It sits directly upstream of the gate-level full adder and feeds that cell with a, b and carry-in each cycle. Operands are loaded in parallel on a start handshake, and the result is returned in parallel with a one-cycle done pulse.

---
 rtl/serial_full_adder_if.sv | 31 +++
 rtl/serial_full_adder.sv | 119 +++++++++++
 tb/tb_serial_full_adder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/serial_full_adder_if.sv
// serial_full_adder_if
//   Operand/result bundle for the bit-serial adder.
//   master : requester side (drives start, a, b, cin; sees busy, done, sum, cout)
//   slave  : adder side
//   start  - request, only honoured while the adder is idle
//   a, b   - WIDTH-bit operands, cin - initial carry
//   busy   - operation in progress
//   done   - one-cycle pulse, sum/cout valid
//   sum    - WIDTH-bit registered result, cout - registered final carry
interface serial_full_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_full_adder.sv
// serial_full_adder
//   Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop,
//   one bit pair per clock, LSB first. Operands load in parallel on an
//   accepted start; the result is returned in parallel with a done pulse.
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - serial_full_adder_if slave modport (start/a/b/cin in,
//         busy/done/sum/cout out)

// Single full-adder gate network; the only arithmetic between registers.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic x;

    assign x  = a ^ b;
    assign s  = x ^ ci;
    assign co = (a & b) | (ci & x);
endmodule

module serial_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_full_adder_if.slave    bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb, acc;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             bit_s, bit_c;
    logic             last;

    fa_cell u_fa (
        .a  (sa[0]),
        .b  (sb[0]),
        .ci (carry),
        .s  (bit_s),
        .co (bit_c)
    );

    assign last = (cnt == LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (last)      state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Datapath: operand shifters, accumulator, carry, bit counter, result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa    <= bus.a;
                        sb    <= bus.b;
                        carry <= bus.cin;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    sa    <= {1'b0, sa[WIDTH-1:1]};
                    sb    <= {1'b0, sb[WIDTH-1:1]};
                    acc   <= {bit_s, acc[WIDTH-1:1]};
                    carry <= bit_c;
                    cnt   <= cnt + 1'b1;
                    // Last bit goes straight into the result, bypassing acc.
                    if (last) begin
                        sum_q  <= {bit_s, acc[WIDTH-1:1]};
                        cout_q <= bit_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_full_adder.sv
module tb_serial_full_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    serial_full_adder_if #(.WIDTH(8)) bus ();
    serial_full_adder_if #(.WIDTH(2)) bus2 ();

    serial_full_adder #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    serial_full_adder #(.WIDTH(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then sample/drive 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation on the 8-bit DUT, start pulsed for a single edge.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [7:0] esum, input logic ecout);
        int edges;
        int busy_n;
        bus.a = a; bus.b = b; bus.cin = cin; bus.start = 1'b1;
        tick();                              // E0
        bus.start = 1'b0;
        edges = 0; busy_n = 0;
        while (!bus.done && edges < 30) begin
            if (bus.busy) busy_n++;
            tick();
            edges++;
        end
        chk({tag, "_lat"},  edges, 8);
        chk({tag, "_busy"}, busy_n, 8);
        chk({tag, "_sum"},  bus.sum, esum);
        chk({tag, "_cout"}, bus.cout, ecout);
        tick();
        chk({tag, "_idle"}, {bus.busy, bus.done}, 2'b00);
        chk({tag, "_hold"}, {bus.cout, bus.sum}, {ecout, esum});
    endtask

    initial begin
        int edges;
        int dn;
        int last_done;
        int zrun;
        logic prev_busy;

        bus.start = 0; bus.a = '0; bus.b = '0; bus.cin = 0;
        bus2.start = 0; bus2.a = '0; bus2.b = '0; bus2.cin = 0;
        #12;
        chk("rst_out", {bus.busy, bus.done, bus.cout, bus.sum}, 11'h000);
        rst = 1'b0;
        tick();

        // Basic vectors
        run_op("t5a3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        run_op("tff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op("tffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // start held through SHIFT and DONE with different operands
        bus.a = 8'h01; bus.b = 8'h01; bus.cin = 0; bus.start = 1;
        tick();
        bus.a = 8'h80; bus.b = 8'h80;
        edges = 0;
        while (!bus.done && edges < 30) begin tick(); edges++; end
        chk("ign_lat", edges, 8);
        chk("ign_sum", {bus.cout, bus.sum}, 9'h002);
        tick();                              // DONE edge, start still high
        bus.start = 0;
        chk("ign_nodone_acc", {bus.busy, bus.done}, 2'b00);
        dn = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (bus.done) dn++; end
        chk("ign_one_done", dn, 0);
        chk("ign_hold", {bus.cout, bus.sum}, 9'h002);

        // Back-to-back with start held high
        bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1; bus.start = 1;
        last_done = -1; zrun = 0; prev_busy = 0; dn = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (bus.done) begin
                dn++;
                chk("b2b_sum", {bus.cout, bus.sum}, 9'h031);
                if (last_done >= 0) chk("b2b_period", k - last_done, 10);
                last_done = k;
            end
            if (!bus.busy) zrun++;
            else begin
                if (!prev_busy && k > 1) chk("b2b_gap", zrun, 2);
                zrun = 0;
            end
            prev_busy = bus.busy;
        end
        chk("b2b_count", dn, 3);
        bus.start = 0;
        edges = 0;
        while (!bus.done && edges < 30) begin tick(); edges++; end
        chk("b2b_drain", bus.done, 1'b1);
        tick();

        // Asynchronous reset mid-SHIFT
        bus.a = 8'h33; bus.b = 8'h44; bus.cin = 0; bus.start = 1;
        tick();
        bus.start = 0;
        repeat (4) tick();
        chk("rst_pre_busy", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async", {bus.busy, bus.done, bus.cout, bus.sum}, 11'h000);
        #1 rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 12; i++) begin tick(); if (bus.done || bus.busy) dn++; end
        chk("rst_no_done", dn, 0);
        chk("rst_sum_zero", {bus.cout, bus.sum}, 9'h000);
        run_op("post_rst", 8'hA5, 8'h0F, 1'b1, 8'hB5, 1'b0);

        // Exhaustive at WIDTH=2
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++) begin
                    bus2.a = 2'(a); bus2.b = 2'(b); bus2.cin = 1'(c); bus2.start = 1;
                    tick();
                    bus2.start = 0;
                    edges = 0;
                    while (!bus2.done && edges < 10) begin tick(); edges++; end
                    chk($sformatf("w2_lat_%0d_%0d_%0d", a, b, c), edges, 2);
                    chk($sformatf("w2_sum_%0d_%0d_%0d", a, b, c),
                        {bus2.cout, bus2.sum}, 32'(a + b + c));
                    tick();
                end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
